// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator response path.
// ACC_RSP_T builds a response struct for a given writeback count and data width.
`ifndef ACC_RSP_T
`define ACC_RSP_T(name, nwb, dw) \
  typedef struct packed { \
    logic [(nwb)-1:0][(dw)-1:0] data; \
    logic [AccRdWidth-1:0]      rd; \
    logic                       error; \
    logic                       dualwb; \
  } name;
`endif

package acc_pkg;

  localparam int unsigned AccRdWidth      = 5;
  localparam int unsigned AccPerfCntWidth = 32;

  `ACC_RSP_T(acc_rsp_t, 1, 32)

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched upward from ptr,
// ptr advances past the winner only when en is high and something is granted.
module acc_rr_arb
  import acc_pkg::*;
#(
  parameter int unsigned NumAcc = 4,
  localparam int unsigned IdxW  = idx_width(NumAcc)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumAcc-1:0] req_i,
  input  logic              en_i,
  output logic [NumAcc-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW:0]   pick_res;

  // Returns {found, index} of the first request at or above ptr, wrapping.
  function automatic logic [IdxW:0] pick(input logic [NumAcc-1:0] req,
                                         input logic [IdxW-1:0] ptr);
    int unsigned     c;
    logic [NumAcc-1:0] sh;
    pick = '0;
    for (int unsigned k = 0; k < NumAcc; k++) begin
      c  = (32'(ptr) + k) % NumAcc;
      sh = req >> c;
      if (!pick[IdxW] && sh[0]) pick = {1'b1, IdxW'(c)};
    end
  endfunction

  always_comb begin
    pick_res = pick(req_i, ptr_q);
    idx_o    = pick_res[IdxW-1:0];
    gnt_o    = pick_res[IdxW] ? (NumAcc'(1) << idx_o) : '0;
    ptr_d    = (32'(idx_o) == NumAcc - 1) ? '0 : idx_o + IdxW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (en_i && pick_res[IdxW]) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/acc_resp_arbiter.sv
// Merges NumAcc accelerator response channels into one registered output stage.
// Define ACC_RESP_ARB_PERF_EN to build the per-channel saturating grant counters.
module acc_resp_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned  NumAcc        = 4,
  parameter int unsigned  DataWidth     = 32,
  parameter bit           DualWriteback = 1'b0,
  localparam int unsigned IdxW          = idx_width(NumAcc),
  localparam int unsigned NumWb         = DualWriteback ? 2 : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumAcc*NumWb*DataWidth-1:0]   in_p_data_i,
  input  logic [NumAcc*AccRdWidth-1:0]        in_p_rd_i,
  input  logic [NumAcc-1:0]                   in_p_error_i,
  input  logic [NumAcc-1:0]                   in_p_dualwb_i,
  input  logic [NumAcc-1:0]                   in_p_valid_i,
  output logic [NumAcc-1:0]                   in_p_ready_o,
  output logic [NumWb*DataWidth-1:0]          out_p_data_o,
  output logic [AccRdWidth-1:0]               out_p_rd_o,
  output logic                                out_p_error_o,
  output logic                                out_p_dualwb_o,
  output logic [IdxW-1:0]                     out_p_src_o,
  output logic                                out_p_valid_o,
  input  logic                                out_p_ready_i,
  output logic [NumAcc*AccPerfCntWidth-1:0]   perf_grant_cnt_o
);

  `ACC_RSP_T(rsp_t, NumWb, DataWidth)

  rsp_t              rsp_q, sel_rsp;
  logic              valid_q;
  logic [IdxW-1:0]   src_q, arb_idx;
  logic [NumAcc-1:0] arb_gnt;
  logic              load_en, arb_en;

  assign load_en = !valid_q || out_p_ready_i;
  // No handshake may complete while reset is held.
  assign arb_en  = load_en && !rst_i;

  acc_rr_arb #(
    .NumAcc(NumAcc)
  ) u_arb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(in_p_valid_i),
    .en_i (arb_en),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );

  assign in_p_ready_o = arb_gnt & {NumAcc{arb_en}};

  always_comb begin
    sel_rsp = '0;
    for (int unsigned i = 0; i < NumAcc; i++) begin
      if (arb_gnt[i]) begin
        sel_rsp.data   = in_p_data_i[i*NumWb*DataWidth +: NumWb*DataWidth];
        sel_rsp.rd     = in_p_rd_i[i*AccRdWidth +: AccRdWidth];
        sel_rsp.error  = in_p_error_i[i];
        sel_rsp.dualwb = DualWriteback && in_p_dualwb_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      rsp_q   <= '0;
      src_q   <= '0;
    end else if (load_en) begin
      valid_q <= |arb_gnt;
      if (|arb_gnt) begin
        rsp_q <= sel_rsp;
        src_q <= arb_idx;
      end
    end
  end

  assign out_p_valid_o  = valid_q;
  assign out_p_data_o   = rsp_q.data;
  assign out_p_rd_o     = rsp_q.rd;
  assign out_p_error_o  = rsp_q.error;
  assign out_p_dualwb_o = rsp_q.dualwb;
  assign out_p_src_o    = src_q;

`ifdef ACC_RESP_ARB_PERF_EN
  for (genvar i = 0; i < NumAcc; i++) begin : g_perf
    logic [AccPerfCntWidth-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (in_p_valid_i[i] && in_p_ready_o[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + AccPerfCntWidth'(1);
      end
    end
    assign perf_grant_cnt_o[i*AccPerfCntWidth +: AccPerfCntWidth] = cnt_q;
  end
`else
  assign perf_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_acc_resp_arbiter.sv
// Scoreboard bench for acc_resp_arbiter (4 channels, dual writeback enabled).
// A reference model predicts grants; accepted responses are queued and compared on output.
module tb_acc_resp_arbiter;

  localparam int NA = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NA*64-1:0] in_p_data_i;
  logic [NA*5-1:0]  in_p_rd_i;
  logic [NA-1:0] in_p_error_i, in_p_dualwb_i, in_p_valid_i, in_p_ready_o;
  logic [63:0]   out_p_data_o;
  logic [4:0]    out_p_rd_o;
  logic          out_p_error_o, out_p_dualwb_o, out_p_valid_o, out_p_ready_i;
  logic [1:0]    out_p_src_o;
  logic [NA*32-1:0] perf_grant_cnt_o;

  acc_resp_arbiter #(
    .NumAcc       (NA),
    .DataWidth    (32),
    .DualWriteback(1'b1)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .in_p_data_i     (in_p_data_i),
    .in_p_rd_i       (in_p_rd_i),
    .in_p_error_i    (in_p_error_i),
    .in_p_dualwb_i   (in_p_dualwb_i),
    .in_p_valid_i    (in_p_valid_i),
    .in_p_ready_o    (in_p_ready_o),
    .out_p_data_o    (out_p_data_o),
    .out_p_rd_o      (out_p_rd_o),
    .out_p_error_o   (out_p_error_o),
    .out_p_dualwb_o  (out_p_dualwb_o),
    .out_p_src_o     (out_p_src_o),
    .out_p_valid_o   (out_p_valid_o),
    .out_p_ready_i   (out_p_ready_i),
    .perf_grant_cnt_o(perf_grant_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        error;
    logic        dualwb;
    logic [1:0]  src;
  } exp_t;

  exp_t        q[$];
  logic [63:0] ch_data[NA];
  logic [4:0]  ch_rd[NA];
  logic        ch_err[NA], ch_dwb[NA];
  int          left[NA];
  logic [31:0] m_cnt[NA];
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic        m_known = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_fields(input int i);
    ch_data[i] = {$urandom, $urandom};
    ch_rd[i]   = 5'($urandom_range(0, 31));
    ch_err[i]  = 1'($urandom_range(0, 1));
    ch_dwb[i]  = 1'($urandom_range(0, 1));
  endtask

  task automatic drive();
    for (int i = 0; i < NA; i++) begin
      in_p_data_i[i*64 +: 64] = ch_data[i];
      in_p_rd_i[i*5 +: 5]     = ch_rd[i];
      in_p_error_i[i]         = ch_err[i];
      in_p_dualwb_i[i]        = ch_dwb[i];
      in_p_valid_i[i]         = (left[i] != 0);
    end
  endtask

  // One clock: predict and check at negedge, update sources just after posedge.
  task automatic step();
    logic         ld;
    int           g;
    logic [NA-1:0] exp_rdy;
    drive();
    @(negedge clk);
    if (m_known) begin
      check("out_valid", 64'(out_p_valid_o), 64'(m_valid));
      if (m_valid && q.size() > 0) begin
        check("out_data", out_p_data_o, q[0].data);
        check("out_rd", 64'(out_p_rd_o), 64'(q[0].rd));
        check("out_error", 64'(out_p_error_o), 64'(q[0].error));
        check("out_dualwb", 64'(out_p_dualwb_o), 64'(q[0].dualwb));
        check("out_src", 64'(out_p_src_o), 64'(q[0].src));
      end
    end
    ld = !m_valid || out_p_ready_i;
    g  = -1;
    if (!rst_i) begin
      for (int k = 0; k < NA; k++) begin
        int c;
        c = (m_ptr + k) % NA;
        if (g < 0 && left[c] != 0) g = c;
      end
    end
    exp_rdy = (ld && g >= 0) ? NA'(1 << g) : '0;
    check("in_ready", 64'(in_p_ready_o), 64'(exp_rdy));
    if (rst_i) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_known = 1'b1;
      q.delete();
      for (int i = 0; i < NA; i++) m_cnt[i] = '0;
      g = -1;
    end else begin
      if (m_valid && out_p_ready_i && q.size() > 0) void'(q.pop_front());
      if (ld) begin
        if (g >= 0) begin
          q.push_back('{data: ch_data[g], rd: ch_rd[g], error: ch_err[g], dualwb: ch_dwb[g],
                        src: 2'(g)});
          m_valid = 1'b1;
          m_ptr   = (g == NA - 1) ? 0 : g + 1;
          if (m_cnt[g] != 32'hFFFF_FFFF) m_cnt[g] = m_cnt[g] + 1;
        end else begin
          m_valid = 1'b0;
        end
      end else begin
        g = -1;
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      left[g]--;
      new_fields(g);
    end
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_p_ready_i = 1'b1;
    while (n < 60 && (q.size() != 0 || left[0] + left[1] + left[2] + left[3] != 0 || m_valid)) begin
      step();
      n++;
    end
    check("drain_done", 64'(q.size()), 64'd0);
  endtask

  task automatic check_zero_out(input string tag);
    check({tag, "_valid"}, 64'(out_p_valid_o), 64'd0);
    check({tag, "_data"}, out_p_data_o, 64'd0);
    check({tag, "_rd"}, 64'(out_p_rd_o), 64'd0);
    check({tag, "_src"}, 64'(out_p_src_o), 64'd0);
    check({tag, "_err_dwb"}, 64'({out_p_error_o, out_p_dualwb_o}), 64'd0);
    check({tag, "_perf"}, 64'(perf_grant_cnt_o[63:0] | perf_grant_cnt_o[127:64]), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    out_p_ready_i = 1'b0;
    for (int i = 0; i < NA; i++) begin
      left[i]  = 0;
      m_cnt[i] = '0;
      new_fields(i);
    end
    step();
    step();
    check_zero_out("reset");
    rst_i = 1'b0;

    // Full load, continuous ready: strict 0,1,2,3 rotation, one per cycle.
    for (int i = 0; i < NA; i++) left[i] = 8;
    out_p_ready_i = 1'b1;
    for (int s = 0; s < 34; s++) step();
    drain();

    // Single channel held under backpressure, then released.
    ch_rd[2]   = 5'd7;
    ch_data[2] = 64'h0000_0000_DEAD_BEEF;
    left[2]    = 1;
    out_p_ready_i = 1'b0;
    step();
    check("ch2_rd", 64'(out_p_rd_o), 64'd7);
    check("ch2_data", out_p_data_o, 64'h0000_0000_DEAD_BEEF);
    step();
    step();
    out_p_ready_i = 1'b1;
    step();
    step();
    check("ch2_single", 64'(out_p_valid_o), 64'd0);

    // ptr now 3: ch3 and ch0 pending, ch3 wins then wrap to ch0.
    left[3] = 1;
    left[0] = 1;
    step();
    check("wrap_src3", 64'(out_p_src_o), 64'd3);
    step();
    check("wrap_src0", 64'(out_p_src_o), 64'd0);
    drain();

    // Dual writeback with error on ch1.
    ch_data[1] = {32'h1, 32'h2};
    ch_dwb[1]  = 1'b1;
    ch_err[1]  = 1'b1;
    left[1]    = 1;
    step();
    check("dual_data", out_p_data_o, {32'h1, 32'h2});
    check("dual_flags", 64'({out_p_dualwb_o, out_p_error_o, out_p_src_o}), 64'b11_01);
    drain();

    // Reset while a response is stalled at the output.
    left[1] = 1;
    out_p_ready_i = 1'b0;
    step();
    step();
    left[1] = 1;
    step();
    rst_i = 1'b1;
    step();
    check_zero_out("midreset");
    rst_i = 1'b0;
    out_p_ready_i = 1'b1;
    for (int i = 0; i < NA; i++) left[i] = 1;
    step();
    check("post_reset_ptr", 64'(out_p_src_o), 64'd0);
    drain();

    // Random traffic and backpressure.
    for (int s = 0; s < 200; s++) begin
      out_p_ready_i = 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < NA; i++) begin
        if (left[i] == 0 && $urandom_range(0, 2) == 0) left[i] = $urandom_range(1, 3);
      end
      step();
    end
    drain();

`ifdef ACC_RESP_ARB_PERF_EN
    for (int i = 0; i < NA; i++) check("perf_cnt", 64'(perf_grant_cnt_o[i*32 +: 32]), 64'(m_cnt[i]));
    force dut.g_perf[0].cnt_q = 32'hFFFF_FFFE;
    m_cnt[0] = 32'hFFFF_FFFE;
    step();
    release dut.g_perf[0].cnt_q;
    left[0] = 3;
    for (int s = 0; s < 6; s++) step();
    check("perf_sat", 64'(perf_grant_cnt_o[31:0]), 64'hFFFF_FFFF);
    check("perf_sat_model", 64'(perf_grant_cnt_o[31:0]), 64'(m_cnt[0]));
`else
    check("perf_tied", 64'(perf_grant_cnt_o[63:0] | perf_grant_cnt_o[127:64]), 64'd0);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
